// File: rtl/mig_ui_responder_if.sv
// MIG 7-series app_* user interface, single-beat 128-bit mode.
// master = DRAM bridge front-end, slave = memory controller (or its stand-in).
interface mig_ui_responder_if #(
    parameter int ADDR_WIDTH = 27
);
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic [127:0]          app_wdf_data;
    logic                  app_wdf_end;
    logic [15:0]           app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic [127:0]          app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;
    logic                  init_calib_complete;
    logic                  cmd_error;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete, cmd_error
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete, cmd_error
    );
endinterface

// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for the MIG app_* interface: calibration delay, backpressure,
// byte-masked writes through a 2-deep write-data FIFO, fixed-latency in-order reads.
module mig_ui_responder #(
    parameter int ADDR_WIDTH   = 27,
    parameter int LINES_LOG2   = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LATENCY   = 4,
    parameter int STALL_PERIOD = 0
) (
    input  logic               clock,
    input  logic               reset,
    mig_ui_responder_if.slave  ui
);
    localparam int LINES = 1 << LINES_LOG2;
    localparam int CW    = ($clog2(CALIB_CYCLES + 1) > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
    localparam int SW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  mask;
    } wdf_ent_t;

    logic [127:0]              mem [LINES];
    wdf_ent_t                  fifo_q [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                fifo_cnt_q;
    logic [CW-1:0]             calib_cnt_q;
    logic                      calib_q, pend_q, err_q;
    logic [LINES_LOG2-1:0]     pend_line_q;
    logic [SW-1:0]             stall_cnt_q;
    logic [RD_LATENCY:0]       vld_pipe_q;
    logic [RD_LATENCY:0][127:0] dat_pipe_q;

    logic [LINES_LOG2-1:0] line;
    logic rdy, wdf_rdy, stall, cmd_acc, wr_acc, rd_acc, bad_acc, push, commit;
    logic unused_addr;

    assign line        = ui.app_addr[LINES_LOG2+3:4];
    assign unused_addr = ^{ui.app_addr[ADDR_WIDTH-1:LINES_LOG2+4], ui.app_addr[3:0]};
    assign stall       = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
    assign rdy         = calib_q && !pend_q && !stall;
    assign wdf_rdy     = calib_q && (fifo_cnt_q != 2'd2);
    assign cmd_acc     = ui.app_en && rdy;
    assign wr_acc      = cmd_acc && (ui.app_cmd == 3'b000);
    assign rd_acc      = cmd_acc && (ui.app_cmd == 3'b001);
    assign bad_acc     = cmd_acc && (ui.app_cmd[2:1] != 2'b00);
    assign push        = ui.app_wdf_wren && wdf_rdy;
    // A beat pushed this cycle into an empty FIFO is not yet visible to the commit.
    assign commit      = !reset && pend_q && (fifo_cnt_q != 2'd0);

    // Storage without reset: array contents survive reset, FIFO slots are gated by pointers.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= {ui.app_wdf_data, ui.app_wdf_mask};
        if (commit) begin
            for (int b = 0; b < 16; b++) begin
                if (!fifo_q[rd_ptr_q].mask[b])
                    mem[pend_line_q][8*b +: 8] <= fifo_q[rd_ptr_q].data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            calib_cnt_q <= '0;
            calib_q     <= 1'b0;
            stall_cnt_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            err_q       <= 1'b0;
            vld_pipe_q  <= '0;
            dat_pipe_q  <= '0;
        end else begin
            if (!calib_q) begin
                calib_cnt_q <= calib_cnt_q + 1'b1;
                if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
            end
            stall_cnt_q <= stall ? '0 : stall_cnt_q + 1'b1;

            if (push)   wr_ptr_q <= ~wr_ptr_q;
            if (commit) rd_ptr_q <= ~rd_ptr_q;
            case ({push, commit})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            // app_rdy is low while pending, so acceptance and commit never coincide.
            if (wr_acc) begin
                pend_q      <= 1'b1;
                pend_line_q <= line;
            end else if (commit) begin
                pend_q <= 1'b0;
            end

            if (bad_acc || (push && !ui.app_wdf_end)) err_q <= 1'b1;

            // Stage 0 is the synchronous array read; each later stage loads only with a
            // valid beat, so the final stage holds the last returned data.
            vld_pipe_q[0] <= rd_acc;
            if (rd_acc) dat_pipe_q[0] <= mem[line];
            for (int k = 1; k <= RD_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
            end
        end
    end

    assign ui.app_rdy             = rdy;
    assign ui.app_wdf_rdy         = wdf_rdy;
    assign ui.app_rd_data         = dat_pipe_q[RD_LATENCY];
    assign ui.app_rd_data_valid   = vld_pipe_q[RD_LATENCY];
    assign ui.app_rd_data_end     = vld_pipe_q[RD_LATENCY];
    assign ui.init_calib_complete = calib_q;
    assign ui.cmd_error           = err_q;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder: calibration, masked/aliased writes, late data,
// back-to-back reads, periodic stall (second instance), illegal command and mid-flight reset.
module tb_mig_ui_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mig_ui_responder_if #(.ADDR_WIDTH(27)) u_if ();
    mig_ui_responder_if #(.ADDR_WIDTH(27)) s_if ();

    mig_ui_responder #(.STALL_PERIOD(0)) dut (
        .clock (clock),
        .reset (reset),
        .ui    (u_if.slave)
    );

    mig_ui_responder #(.STALL_PERIOD(3)) dut_st (
        .clock (clock),
        .reset (reset),
        .ui    (s_if.slave)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Edges since reset release; the stall instance's free-running counter tracks this mod 3.
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    typedef struct {
        bit           wr;
        logic [26:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] EXPL = 128'h00112233_44556677_8899AABB_AAAAAAAA;
    localparam logic [127:0] SA   = 128'hA5A50001_A5A50002_A5A50003_A5A50004;
    localparam logic [127:0] SB   = 128'h5A5A1001_5A5A1002_5A5A1003_5A5A1004;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_cmd(input logic [2:0] cmd, input logic [26:0] addr);
        int n = 0;
        u_if.app_cmd  = cmd;
        u_if.app_addr = addr;
        u_if.app_en   = 1'b1;
        while (!u_if.app_rdy && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_rdy_timeout", 128'(n < 200), 128'd1);
        tick();
        u_if.app_en = 1'b0;
    endtask

    task automatic push_data(input logic [127:0] data, input logic [15:0] mask);
        int n = 0;
        u_if.app_wdf_data = data;
        u_if.app_wdf_mask = mask;
        u_if.app_wdf_end  = 1'b1;
        u_if.app_wdf_wren = 1'b1;
        while (!u_if.app_wdf_rdy && n < 200) begin
            tick();
            n++;
        end
        chk("wdf_rdy_timeout", 128'(n < 200), 128'd1);
        tick();
        u_if.app_wdf_wren = 1'b0;
    endtask

    // Data first, then command: pending for exactly one cycle, then committed.
    task automatic wr_line(input logic [26:0] addr, input logic [127:0] data, input logic [15:0] mask);
        push_data(data, mask);
        do_cmd(3'b000, addr);
        chk("wr_pending_rdy", 128'(u_if.app_rdy), 128'd0);
        tick();
        chk("wr_commit_rdy", 128'(u_if.app_rdy), 128'd1);
    endtask

    // Beat must show up on the 4th edge after the accepting edge, for one cycle only.
    task automatic rd_line(input logic [26:0] addr, input logic [127:0] exp, input string nm);
        do_cmd(3'b001, addr);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk({nm, "_valid"}, 128'(u_if.app_rd_data_valid), 128'(k == 4));
        end
        chk({nm, "_data"}, u_if.app_rd_data, exp);
        chk({nm, "_end"}, 128'(u_if.app_rd_data_end), 128'd1);
        tick();
        chk({nm, "_valid_drop"}, 128'(u_if.app_rd_data_valid), 128'd0);
    endtask

    vec_t vecs[9];
    logic [127:0] q[$];

    initial begin
        int nval, nacc, n;
        vecs[0] = '{1'b1, 27'h0040,   D1,            16'h0000, 128'h0};
        vecs[1] = '{1'b0, 27'h0040,   128'h0,        16'h0000, D1};
        vecs[2] = '{1'b1, 27'h0050,   {16{8'h5A}},   16'h0000, 128'h0};
        vecs[3] = '{1'b1, 27'h0050,   {16{8'hC3}},   16'hFF00, 128'h0};
        vecs[4] = '{1'b0, 27'h0050,   128'h0,        16'h0000, {{8{8'h5A}}, {8{8'hC3}}}};
        vecs[5] = '{1'b1, 27'h4050,   {16{8'hEE}},   16'hFFFE, 128'h0};
        vecs[6] = '{1'b0, 27'h0050,   128'h0,        16'h0000, {{8{8'h5A}}, {7{8'hC3}}, 8'hEE}};
        vecs[7] = '{1'b1, 27'h7FF0,   128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0, 16'h0000, 128'h0};
        vecs[8] = '{1'b0, 27'h7FF0,   128'h0,        16'h0000, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0};

        u_if.app_addr = '0; u_if.app_cmd = 3'b001; u_if.app_en = 1'b1;
        u_if.app_wdf_data = '0; u_if.app_wdf_end = 1'b0; u_if.app_wdf_mask = '0; u_if.app_wdf_wren = 1'b0;
        s_if.app_addr = '0; s_if.app_cmd = 3'b000; s_if.app_en = 1'b0;
        s_if.app_wdf_data = '0; s_if.app_wdf_end = 1'b0; s_if.app_wdf_mask = '0; s_if.app_wdf_wren = 1'b0;

        // Reset and calibration with app_en held high
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_flags", 128'({u_if.app_rdy, u_if.app_wdf_rdy, u_if.app_rd_data_valid,
                                 u_if.app_rd_data_end, u_if.init_calib_complete, u_if.cmd_error}), 128'd0);
        chk("reset_rd_data", u_if.app_rd_data, 128'd0);
        reset = 1'b0;
        nval = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk("calib", 128'(u_if.init_calib_complete), 128'(i == 64));
            chk("calib_rdy", 128'(u_if.app_rdy), 128'(i == 64));
            if (u_if.app_rd_data_valid) nval++;
        end
        u_if.app_en = 1'b0;
        repeat (8) begin
            tick();
            if (u_if.app_rd_data_valid) nval++;
        end
        chk("no_early_accept", 128'(nval), 128'd0);

        // Stall instance: fill two lines, then continuous reads against the 1,1,0 pattern
        for (int w = 0; w < 2; w++) begin
            s_if.app_wdf_data = (w == 0) ? SA : SB;
            s_if.app_wdf_end  = 1'b1;
            s_if.app_wdf_wren = 1'b1;
            chk("st_wdf_rdy", 128'(s_if.app_wdf_rdy), 128'd1);
            tick();
            s_if.app_wdf_wren = 1'b0;
            s_if.app_cmd  = 3'b000;
            s_if.app_addr = (w == 0) ? 27'h00 : 27'h10;
            s_if.app_en   = 1'b1;
            n = 0;
            while (!s_if.app_rdy && n < 10) begin
                tick();
                n++;
            end
            tick();
            s_if.app_en = 1'b0;
            repeat (2) tick();
        end
        s_if.app_cmd = 3'b001;
        s_if.app_en  = 1'b1;
        nacc = 0;
        for (int j = 0; j < 18; j++) begin
            if (s_if.app_rd_data_valid) begin
                if (q.size() == 0) chk("st_extra_beat", 128'd1, 128'd0);
                else chk("st_data", s_if.app_rd_data, q.pop_front());
            end
            if (j < 12) begin
                chk("st_rdy", 128'(s_if.app_rdy), 128'((cyc % 3) != 2));
                s_if.app_addr = (j % 2 == 1) ? 27'h10 : 27'h00;
                if (s_if.app_rdy) begin
                    q.push_back((j % 2 == 1) ? SB : SA);
                    nacc++;
                end
            end else begin
                s_if.app_en = 1'b0;
            end
            tick();
        end
        chk("st_accepts", 128'(nacc), 128'd8);
        chk("st_all_beats", 128'(q.size()), 128'd0);

        // Vector table: full, masked and aliased writes with read-back
        foreach (vecs[i]) begin
            if (vecs[i].wr) wr_line(vecs[i].addr, vecs[i].data, vecs[i].mask);
            else rd_line(vecs[i].addr, vecs[i].exp, "vec");
        end

        // Back-to-back reads of lines holding their own index
        for (int i = 0; i < 8; i++) wr_line(27'(i * 16), 128'(i), 16'h0000);
        u_if.app_cmd  = 3'b001;
        u_if.app_addr = 27'h0;
        u_if.app_en   = 1'b1;
        for (int j = 0; j < 13; j++) begin
            if (j < 8) chk("b2b_rdy", 128'(u_if.app_rdy), 128'd1);
            tick();
            if (j < 7) u_if.app_addr = 27'((j + 1) * 16);
            else u_if.app_en = 1'b0;
            chk("b2b_valid", 128'(u_if.app_rd_data_valid), 128'(j >= 4 && j <= 11));
            if (j >= 4 && j <= 11) chk("b2b_data", u_if.app_rd_data, 128'(j - 4));
        end

        // Command first, data 10 cycles later
        wr_line(27'h40, D1, 16'h0000);
        do_cmd(3'b000, 27'h40);
        for (int i = 0; i < 10; i++) begin
            chk("late_rdy_low", 128'(u_if.app_rdy), 128'd0);
            tick();
        end
        u_if.app_wdf_data = {16{8'hAA}};
        u_if.app_wdf_mask = 16'hFFF0;
        u_if.app_wdf_end  = 1'b1;
        u_if.app_wdf_wren = 1'b1;
        chk("late_wdf_rdy", 128'(u_if.app_wdf_rdy), 128'd1);
        tick();
        u_if.app_wdf_wren = 1'b0;
        chk("late_push_no_commit", 128'(u_if.app_rdy), 128'd0);
        tick();
        chk("late_commit", 128'(u_if.app_rdy), 128'd1);
        rd_line(27'h40, EXPL, "late");

        // Illegal command, then reset with two reads in flight
        chk("err_clear", 128'(u_if.cmd_error), 128'd0);
        do_cmd(3'b101, 27'h40);
        chk("err_set", 128'(u_if.cmd_error), 128'd1);
        rd_line(27'h40, EXPL, "illegal_nop");
        u_if.app_cmd  = 3'b001;
        u_if.app_addr = 27'h40;
        u_if.app_en   = 1'b1;
        chk("inflight_rdy0", 128'(u_if.app_rdy), 128'd1);
        tick();
        u_if.app_addr = 27'h00;
        chk("inflight_rdy1", 128'(u_if.app_rdy), 128'd1);
        tick();
        u_if.app_en = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_err", 128'(u_if.cmd_error), 128'd0);
        chk("rst_valid", 128'(u_if.app_rd_data_valid), 128'd0);
        chk("rst_rd_data", u_if.app_rd_data, 128'd0);
        chk("rst_calib", 128'(u_if.init_calib_complete), 128'd0);
        reset = 1'b0;
        nval = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (u_if.app_rd_data_valid) nval++;
        end
        chk("dropped_reads", 128'(nval), 128'd0);
        chk("recalib", 128'(u_if.init_calib_complete), 128'd1);
        rd_line(27'h40, EXPL, "retained");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Synthesizable, BRAM-backed responder for the MIG 7-series user (app_*) interface, single-beat 128-bit mode.
- Stands in for the MIG core so the DRAM bridge front-end can be simulated and brought up on FPGA without a DDR2 part.
- Models calibration delay, command/data backpressure, byte-masked writes and fixed read latency.

Parameters:
- ADDR_WIDTH, 27, width of app_addr.
- LINES_LOG2, 10, log2 of the number of 128-bit lines stored.
- CALIB_CYCLES, 64, cycles after reset before init_calib_complete rises.
- RD_LATENCY, 4, cycles from read-command acceptance to the read-data beat (legal range 1..15).
- STALL_PERIOD, 0, app_rdy forced low one cycle in every STALL_PERIOD cycles; 0 means never.

Ports:
- clock  in  1  ui clock
- reset  in  1  synchronous, active-high
- app_addr  in  ADDR_WIDTH  byte address; bits [3:0] ignored
- app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
- app_en  in  1  command valid
- app_wdf_data  in  128  write data
- app_wdf_end  in  1  last beat; must be 1 with app_wdf_wren
- app_wdf_mask  in  16  bit i = 1 suppresses byte i, i.e. data[8i+7:8i]
- app_wdf_wren  in  1  write data valid
- app_rdy  out  1  command accepted when app_en && app_rdy
- app_wdf_rdy  out  1  data accepted when app_wdf_wren && app_wdf_rdy
- app_rd_data  out  128  read data
- app_rd_data_valid  out  1  read beat valid
- app_rd_data_end  out  1  equals app_rd_data_valid
- init_calib_complete  out  1  calibration done
- cmd_error  out  1  sticky illegal-command or wdf-protocol flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Port names are clock and reset.
- Reset values: every output 0, calib counter 0, write-data FIFO empty, pending write cleared, read pipeline empty, stall counter 0. Memory array contents are retained.
- Calibration:
  - Counter increments each cycle after reset. init_calib_complete is set when the counter reaches CALIB_CYCLES, i.e. CALIB_CYCLES cycles after reset deasserts.
  - init_calib_complete is sticky until the next reset.
  - Before calibration completes, app_rdy = app_wdf_rdy = 0.
- Write-data FIFO:
  - 2 entries of {data, mask}.
  - app_wdf_rdy = calib && FIFO not full.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A wren with app_wdf_end = 0 sets cmd_error; the beat is still stored.
- app_rdy = calib && !pending_write && !stall_cycle.
  - stall_cycle is high when STALL_PERIOD != 0 and the free-running stall counter equals STALL_PERIOD-1. The counter wraps to 0 at that point.
- Accepted write command:
  - Latches line = app_addr[LINES_LOG2+3:4] into the pending-write register. Higher address bits alias.
  - Commit happens in the first cycle the pending write is set and the FIFO is non-empty. This includes a push arriving in that same cycle only if the FIFO was already non-empty.
  - On commit: write every byte whose mask bit is 0, pop the FIFO, clear pending.
  - Earliest commit is 1 cycle after acceptance.
  - Data may arrive before or after its command; FIFO order pairs data with commands.
- Accepted read command:
  - The array is read with 1-cycle synchronous read and the result flows through a delay line.
  - app_rd_data_valid = app_rd_data_end = 1 for exactly one cycle, RD_LATENCY cycles after the acceptance edge.
  - Back-to-back reads are accepted every cycle and return in order, one beat per cycle.
  - Reads are never blocked by the read pipeline.
- Ordering:
  - app_rdy is low while a write is pending, so a read accepted after a write always observes that write.
  - A read issued in the same cycle a write commits does not happen, because app_rdy is low in that cycle.
- Illegal app_cmd: the command is accepted (app_rdy handshake), has no memory effect, and sets cmd_error.
- app_rd_data holds its last value when not valid. It resets to 0.
- Reset mid-operation:
  - In-flight reads are dropped with no valid beat.
  - The pending write and FIFO contents are discarded with no commit.
  - Calibration restarts.

Test Plan:
- Reset, hold app_en = 1 → app_rdy = 0 and init_calib_complete = 0 for 64 cycles; both go to 1 on cycle 64; no command is accepted earlier.
- Data beat 0x00112233_44556677_8899AABB_CCDDEEFF with mask 0x0000, then write command to addr 0x40; then read 0x40 → valid for 1 cycle exactly 4 cycles after read accept, data matches, end = 1.
- Write command to 0x40 first, data 10 cycles later with mask 0xFFF0 and data all 0xAA → app_rdy low until commit; read 0x40 returns the prior line with only bytes [3:0] = 0xAA.
- 8 back-to-back reads of addrs 0x00..0x70, with lines pre-filled with index values → 8 consecutive valid beats in issue order, starting 4 cycles after the first accept.
- STALL_PERIOD = 3 with continuous app_en reads → app_rdy pattern 1,1,0 repeating; exactly 2 accepts per 3 cycles; read data still correct.
- app_cmd = 3'b101 accepted → cmd_error = 1 and memory unchanged. Then assert reset with 2 reads in flight → no valid beat, cmd_error = 0, and after recalibration a read of 0x40 returns the value written before the reset.
